// File: rtl/wb_arbiter_rr_pkg.sv
// Shared constants and state encoding for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bus bundle between NUM_MASTERS Wishbone requesters, the arbiter and the downstream mux.
// Modport slave is the arbiter's view; modport master is the surrounding system's view.
interface wb_arbiter_rr_if #(
    parameter int NUM_MASTERS = 2
);
    import wb_arb_pkg::*;

    logic [NUM_MASTERS*WB_ADR_W-1:0] wbm_adr_i;
    logic [NUM_MASTERS*WB_DAT_W-1:0] wbm_dat_i;
    logic [NUM_MASTERS*WB_SEL_W-1:0] wbm_sel_i;
    logic [NUM_MASTERS*3-1:0]        wbm_cti_i;
    logic [NUM_MASTERS*2-1:0]        wbm_bte_i;
    logic [NUM_MASTERS-1:0]          wbm_we_i;
    logic [NUM_MASTERS-1:0]          wbm_cyc_i;
    logic [NUM_MASTERS-1:0]          wbm_stb_i;
    logic [NUM_MASTERS*WB_DAT_W-1:0] wbm_dat_o;
    logic [NUM_MASTERS-1:0]          wbm_ack_o;
    logic [NUM_MASTERS-1:0]          wbm_err_o;
    logic [NUM_MASTERS-1:0]          wbm_rty_o;

    logic [WB_ADR_W-1:0]             wbs_adr_o;
    logic [WB_DAT_W-1:0]             wbs_dat_o;
    logic [WB_SEL_W-1:0]             wbs_sel_o;
    logic [2:0]                      wbs_cti_o;
    logic [1:0]                      wbs_bte_o;
    logic                            wbs_we_o;
    logic                            wbs_cyc_o;
    logic                            wbs_stb_o;
    logic [WB_DAT_W-1:0]             wbs_dat_i;
    logic                            wbs_ack_i;
    logic                            wbs_err_i;
    logic                            wbs_rty_i;

    logic [NUM_MASTERS-1:0]          arb_gnt_o;
    arb_state_e                      arb_state_o;

    // Handshake: a transfer beat completes on any clock edge where cyc and stb are high
    // and exactly one of ack/err/rty is returned; the granted master holds cyc for its burst.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        input  wbm_we_i, wbm_cyc_i, wbm_stb_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
        output wbs_we_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output arb_gnt_o, arb_state_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_cti_i, wbm_bte_i,
        output wbm_we_i, wbm_cyc_i, wbm_stb_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o,
        input  wbs_we_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  arb_gnt_o, arb_state_o
    );

endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational rotating-priority picker: the first requester after i_last (mod NM) wins.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = $clog2(NM)
) (
    input  logic [NM-1:0] i_req,
    input  logic [IW-1:0] i_last,
    output logic [NM-1:0] o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_j;

    // Walk from lowest priority (i_last itself) to highest so the nearest requester lands last.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int k = NM; k >= 1; k--) begin
            w_j = IW'((int'(i_last) + k) % NM);
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 arbiter holding the grant for a whole cyc; optional bus-hang
// watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    wb_arbiter_rr_if.slave  bus
);

    localparam int NM = NUM_MASTERS;
    localparam int IW = $clog2(NM);

    arb_state_e    r_state;
    logic [NM-1:0] r_gnt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_last;

    arb_state_e    w_state_nxt;
    logic [NM-1:0] w_gnt_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] w_last_nxt;

    logic [NM-1:0] w_pick_gnt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic [IW-1:0] w_pick_last;

    logic          w_owned;
    logic          w_cyc_g;
    logic          w_stb_g;
    logic          w_fire;
    logic          w_kill;

    logic [NM-1:0][WB_ADR_W-1:0] w_adr_v;
    logic [NM-1:0][WB_DAT_W-1:0] w_dat_v;
    logic [NM-1:0][WB_SEL_W-1:0] w_sel_v;
    logic [NM-1:0][2:0]          w_cti_v;
    logic [NM-1:0][1:0]          w_bte_v;
    logic [NM-1:0][WB_DAT_W-1:0] w_mdat;
    logic [NM-1:0]               w_mack;
    logic [NM-1:0]               w_merr;
    logic [NM-1:0]               w_mrty;

    logic [WB_ADR_W-1:0] w_s_adr;
    logic [WB_DAT_W-1:0] w_s_dat;
    logic [WB_SEL_W-1:0] w_s_sel;
    logic [2:0]          w_s_cti;
    logic [1:0]          w_s_bte;
    logic                w_s_we;
    logic                w_s_cyc;
    logic                w_s_stb;

    assign w_adr_v = bus.wbm_adr_i;
    assign w_dat_v = bus.wbm_dat_i;
    assign w_sel_v = bus.wbm_sel_i;
    assign w_cti_v = bus.wbm_cti_i;
    assign w_bte_v = bus.wbm_bte_i;

    assign w_owned = (r_state == OWNED);
    assign w_cyc_g = bus.wbm_cyc_i[r_idx];
    assign w_stb_g = bus.wbm_stb_i[r_idx];

    // While owned the picker is only consulted at release, when the owner is the reference.
    assign w_pick_last = w_owned ? r_idx : r_last;

    wb_arb_rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .i_req   (bus.wbm_cyc_i),
        .i_last  (w_pick_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_last  <= IW'(NM - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = OWNED;
                    w_gnt_nxt   = w_pick_gnt;
                    w_idx_nxt   = w_pick_idx;
                end
            end
            OWNED: begin
                if (!w_cyc_g) begin
                    w_last_nxt = r_idx;
                    if (w_pick_valid) begin
                        w_gnt_nxt = w_pick_gnt;
                        w_idx_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_to_kill;
    logic          w_resp;

    assign w_resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    // The TIMEOUT_CYCLES-th stalled cycle fires the error and cuts the slave off at once.
    assign w_fire = w_owned & w_cyc_g & w_stb_g & ~r_to_kill & (r_to_cnt == TO_LAST);
    assign w_kill = r_to_kill | w_fire;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_to_cnt  <= '0;
            r_to_kill <= 1'b0;
        end else begin
            if (!w_owned || !w_cyc_g || !w_stb_g || w_resp || w_kill) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CW'(1);
            end
            if (!w_owned || !w_cyc_g) begin
                r_to_kill <= 1'b0;
            end else if (w_fire) begin
                r_to_kill <= 1'b1;
            end
        end
    end
`else
    assign w_fire = 1'b0;
    assign w_kill = 1'b0;
`endif

    always_comb begin
        w_s_adr = '0;
        w_s_dat = '0;
        w_s_sel = '0;
        w_s_cti = '0;
        w_s_bte = '0;
        w_s_we  = 1'b0;
        w_s_cyc = 1'b0;
        w_s_stb = 1'b0;
        w_mdat  = '0;
        w_mack  = '0;
        w_merr  = '0;
        w_mrty  = '0;
        if (w_owned) begin
            w_s_adr = w_adr_v[r_idx];
            w_s_dat = w_dat_v[r_idx];
            w_s_sel = w_sel_v[r_idx];
            w_s_cti = w_cti_v[r_idx];
            w_s_bte = w_bte_v[r_idx];
            w_s_we  = bus.wbm_we_i[r_idx];
            w_s_cyc = w_cyc_g & ~w_kill;
            w_s_stb = w_stb_g & ~w_kill;
            w_mdat[r_idx] = bus.wbs_dat_i;
            w_mack[r_idx] = bus.wbs_ack_i & ~w_kill;
            w_merr[r_idx] = (bus.wbs_err_i & ~w_kill) | w_fire;
            w_mrty[r_idx] = bus.wbs_rty_i & ~w_kill;
        end
    end

    assign bus.wbs_adr_o   = w_s_adr;
    assign bus.wbs_dat_o   = w_s_dat;
    assign bus.wbs_sel_o   = w_s_sel;
    assign bus.wbs_cti_o   = w_s_cti;
    assign bus.wbs_bte_o   = w_s_bte;
    assign bus.wbs_we_o    = w_s_we;
    assign bus.wbs_cyc_o   = w_s_cyc;
    assign bus.wbs_stb_o   = w_s_stb;
    assign bus.wbm_dat_o   = w_mdat;
    assign bus.wbm_ack_o   = w_mack;
    assign bus.wbm_err_o   = w_merr;
    assign bus.wbm_rty_o   = w_mrty;
    assign bus.arb_gnt_o   = r_gnt;
    assign bus.arb_state_o = r_state;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr with two masters; vector table plus multi-cycle sequences.
module tb_wb_arbiter_rr;
    import wb_arb_pkg::*;

`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    wb_arbiter_rr_if #(.NUM_MASTERS(2)) bus ();

    wb_arbiter_rr #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] sdat;
        logic [1:0]  e_gnt;
        logic        e_scyc;
        logic        e_sstb;
        logic [31:0] e_adr;
        logic [1:0]  e_ack;
        logic [1:0]  e_err;
        logic [1:0]  e_rty;
        logic [31:0] e_dat0;
        logic [31:0] e_dat1;
    } vec_t;

    vec_t vecs [12];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "time limit");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] cyc, input logic [1:0] stb,
                       input logic ack, input logic err, input logic rty);
        bus.wbm_cyc_i = cyc;
        bus.wbm_stb_i = stb;
        bus.wbs_ack_i = ack;
        bus.wbs_err_i = err;
        bus.wbs_rty_i = rty;
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.wbm_adr_i = {32'h0000_2000, 32'h0000_1000};
        bus.wbm_dat_i = {32'h1111_0002, 32'h1111_0001};
        bus.wbm_sel_i = {4'h3, 4'hF};
        bus.wbm_cti_i = {3'b000, 3'b000};
        bus.wbm_bte_i = {2'b00, 2'b00};
        bus.wbm_we_i  = 2'b10;
        bus.wbs_dat_i = '0;
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        //          cyc    stb    ack   err   rty   sdat           gnt    scyc  sstb  adr            ack    err    rty    dat0           dat1
        vecs[0]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[2]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000, 2'b01, 1'b1, 1'b1, 32'h0000_1000, 2'b00, 2'b00, 2'b00, 32'hDEAD_0000, 32'h0};
        vecs[3]  = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 2'b01, 1'b1, 1'b1, 32'h0000_1000, 2'b01, 2'b00, 2'b00, 32'hCAFE_0001, 32'h0};
        vecs[4]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0000_1000, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[6]  = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[7]  = '{2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'b01, 1'b1, 1'b1, 32'h0000_1000, 2'b00, 2'b00, 2'b01, 32'h1234_5678, 32'h0};
        vecs[8]  = '{2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0000_1000, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[9]  = '{2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 32'hBEEF_0002, 2'b10, 1'b1, 1'b1, 32'h0000_2000, 2'b00, 2'b10, 2'b00, 32'h0,         32'hBEEF_0002};
        vecs[10] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b10, 1'b0, 1'b0, 32'h0000_2000, 2'b00, 2'b00, 2'b00, 32'h0,         32'h0};
        vecs[11] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         32'h0};

        repeat (2) step();
        chk("reset gnt", 32'(bus.arb_gnt_o), 32'h0);
        chk("reset cyc", 32'(bus.wbs_cyc_o), 32'h0);
        chk("reset state", 32'(bus.arb_state_o), 32'(IDLE));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            drv(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].err, vecs[i].rty);
            bus.wbs_dat_i = vecs[i].sdat;
            #2;
            chk($sformatf("v%0d gnt", i),  32'(bus.arb_gnt_o), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d scyc", i), 32'(bus.wbs_cyc_o), 32'(vecs[i].e_scyc));
            chk($sformatf("v%0d sstb", i), 32'(bus.wbs_stb_o), 32'(vecs[i].e_sstb));
            chk($sformatf("v%0d adr", i),  bus.wbs_adr_o,      vecs[i].e_adr);
            chk($sformatf("v%0d ack", i),  32'(bus.wbm_ack_o), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d err", i),  32'(bus.wbm_err_o), 32'(vecs[i].e_err));
            chk($sformatf("v%0d rty", i),  32'(bus.wbm_rty_o), 32'(vecs[i].e_rty));
            chk($sformatf("v%0d dat0", i), bus.wbm_dat_o[31:0],  vecs[i].e_dat0);
            chk($sformatf("v%0d dat1", i), bus.wbm_dat_o[63:32], vecs[i].e_dat1);
            step();
        end
        bus.wbs_dat_i = '0;

        // Both masters contend repeatedly: strict alternation with one idle cycle per handover.
        drv(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        #2;
        chk("b2b start gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();
        for (int g = 0; g < 4; g++) begin
            logic [1:0] oh;
            oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            drv(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
            #2;
            chk($sformatf("b2b%0d gnt", g),  32'(bus.arb_gnt_o), 32'(oh));
            chk($sformatf("b2b%0d scyc", g), 32'(bus.wbs_cyc_o), 32'h1);
            chk($sformatf("b2b%0d ack", g),  32'(bus.wbm_ack_o), 32'(oh));
            step();
            drv(~oh, ~oh, 1'b0, 1'b0, 1'b0);
            #2;
            chk($sformatf("b2b%0d hand gnt", g),  32'(bus.arb_gnt_o), 32'(oh));
            chk($sformatf("b2b%0d hand scyc", g), 32'(bus.wbs_cyc_o), 32'h0);
            step();
        end
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        chk("b2b fifth gnt", 32'(bus.arb_gnt_o), 32'h1);
        step();
        #2;
        chk("b2b idle gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();

        // m1 4-beat incrementing burst while m0 waits.
        bus.wbm_cti_i = {3'b010, 3'b000};
        drv(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        #2;
        chk("burst req gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.wbm_adr_i = {32'h0000_2000 + 32'(4 * k), 32'h0000_1000};
            bus.wbm_cti_i = {(k == 3) ? CTI_EOB : 3'b010, 3'b000};
            drv(2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
            #2;
            chk($sformatf("burst%0d gnt", k), 32'(bus.arb_gnt_o), 32'h2);
            chk($sformatf("burst%0d adr", k), bus.wbs_adr_o, 32'h0000_2000 + 32'(4 * k));
            chk($sformatf("burst%0d cti", k), 32'(bus.wbs_cti_o), (k == 3) ? 32'h7 : 32'h2);
            chk($sformatf("burst%0d we", k),  32'(bus.wbs_we_o), 32'h1);
            chk($sformatf("burst%0d sel", k), 32'(bus.wbs_sel_o), 32'h3);
            chk($sformatf("burst%0d ack", k), 32'(bus.wbm_ack_o), 32'h2);
            step();
        end
        bus.wbm_adr_i = {32'h0000_2000, 32'h0000_1000};
        bus.wbm_cti_i = {3'b000, 3'b000};
        drv(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        #2;
        chk("burst end gnt", 32'(bus.arb_gnt_o), 32'h2);
        chk("burst end scyc", 32'(bus.wbs_cyc_o), 32'h0);
        step();
        #2;
        chk("after burst gnt", 32'(bus.arb_gnt_o), 32'h1);
        chk("after burst adr", bus.wbs_adr_o, 32'h0000_1000);
        chk("after burst we", 32'(bus.wbs_we_o), 32'h0);
        step();
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        #2;
        chk("burst idle gnt", 32'(bus.arb_gnt_o), 32'h0);

        // Asynchronous reset pulse while m1 owns the bus.
        drv(2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        drv(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        #2;
        chk("prerst gnt", 32'(bus.arb_gnt_o), 32'h2);
        chk("prerst scyc", 32'(bus.wbs_cyc_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst scyc", 32'(bus.wbs_cyc_o), 32'h0);
        chk("rst sstb", 32'(bus.wbs_stb_o), 32'h0);
        chk("rst gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();
        rst_n = 1'b1;
        #2;
        chk("postrst gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();
        #2;
        chk("postrst first gnt", 32'(bus.arb_gnt_o), 32'h1);
        chk("postrst adr", bus.wbs_adr_o, 32'h0000_1000);
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        step();

        // Slave never answers m0; watchdog behaviour depends on the build.
        drv(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        #2;
        chk("stall req gnt", 32'(bus.arb_gnt_o), 32'h0);
        step();
        for (int k = 1; k <= 12; k++) begin
            logic       e_stb;
            logic [1:0] e_err;
            logic [1:0] e_ack;
            drv(2'b11, 2'b11, (k == 10), 1'b0, 1'b0);
            e_stb = TO_EN ? (k < 8) : 1'b1;
            e_err = (TO_EN && k == 8) ? 2'b01 : 2'b00;
            e_ack = (k == 10 && !TO_EN) ? 2'b01 : 2'b00;
            #2;
            chk($sformatf("stall%0d gnt", k),  32'(bus.arb_gnt_o), 32'h1);
            chk($sformatf("stall%0d sstb", k), 32'(bus.wbs_stb_o), 32'(e_stb));
            chk($sformatf("stall%0d scyc", k), 32'(bus.wbs_cyc_o), 32'(e_stb));
            chk($sformatf("stall%0d err", k),  32'(bus.wbm_err_o), 32'(e_err));
            chk($sformatf("stall%0d ack", k),  32'(bus.wbm_ack_o), 32'(e_ack));
            step();
        end
        drv(2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        #2;
        chk("stall drop gnt", 32'(bus.arb_gnt_o), 32'h1);
        step();
        #2;
        chk("stall next gnt", 32'(bus.arb_gnt_o), 32'h2);
        chk("stall next scyc", 32'(bus.wbs_cyc_o), 32'h1);
        chk("stall next adr", bus.wbs_adr_o, 32'h0000_2000);
        drv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
